// File: rtl/alaghi_adder_top.sv
// ============================================================================
//  Module      : alaghi_adder_top
//  Description : Stochastic-computing scaled adder. Emits x when the operands
//                agree and an alternating toggle bit when they disagree, giving
//                out ~ (P(x)+P(y))/2 independent of operand correlation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alaghi_adder_top #(
    parameter logic INIT_TOGGLE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    output logic out
);

    logic toggle_q;
    logic toggle_d;
    logic w_mismatch;

    assign w_mismatch = x ^ y;

    always_comb begin
        toggle_d = toggle_q;
        if (w_mismatch) begin
            toggle_d = ~toggle_q;
        end
    end

    // Reset forces the output low even though toggle_q may still be undefined.
    always_comb begin
        out = 1'b0;
        if (!rst) begin
            out = w_mismatch ? toggle_q : x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= INIT_TOGGLE;
        end else begin
            toggle_q <= toggle_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alaghi_adder_top.sv
// ============================================================================
//  Module      : tb_alaghi_adder_top
//  Description : Self-checking bench for alaghi_adder_top, both toggle seeds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alaghi_adder_top;

    logic clk;
    logic rst;
    logic x;
    logic y;
    logic out1;
    logic out0;

    int   total;
    int   bad;

    logic q1[$];
    logic q0[$];
    logic p1;
    logic p0;
    logic e1;
    logic e0;

    alaghi_adder_top #(.INIT_TOGGLE(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .out (out1)
    );

    alaghi_adder_top #(.INIT_TOGGLE(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .out (out0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: output on a mismatch is the seed flipped once per earlier mismatch.
    task automatic drive(input logic xi, input logic yi, input logic ri);
        @(negedge clk);
        x   = xi;
        y   = yi;
        rst = ri;
        if (ri) begin
            q1.push_back(1'b0);
            q0.push_back(1'b0);
        end else if (xi == yi) begin
            q1.push_back(xi);
            q0.push_back(xi);
        end else begin
            q1.push_back(p1);
            q0.push_back(p0);
        end
        if (ri) begin
            p1 = 1'b1;
            p0 = 1'b0;
        end else if (xi != yi) begin
            p1 = ~p1;
            p0 = ~p0;
        end
        #2;
    endtask

    task automatic test_reset();
        logic [1:0] combos [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            drive(combos[i][1], combos[i][0], 1'b1);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 2;
            if (out1 !== e1 || out1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_out1[%0d] got=%b want=0", i, out1);
            end
            if (out0 !== e0 || out0 !== 1'b0) begin
                bad++;
                $display("FAIL reset_out0[%0d] got=%b want=0", i, out0);
            end
        end
    endtask

    task automatic test_basic_sequence();
        logic xs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic ys [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ex [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        drive(1'b0, 1'b0, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(xs[i], ys[i], 1'b0);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 3;
            if (out1 !== ex[i]) begin
                bad++;
                $display("FAIL basic_table[%0d] got=%b want=%b", i, out1, ex[i]);
            end
            if (out1 !== e1) begin
                bad++;
                $display("FAIL basic_model1[%0d] got=%b want=%b", i, out1, e1);
            end
            if (out0 !== e0) begin
                bad++;
                $display("FAIL basic_model0[%0d] got=%b want=%b", i, out0, e0);
            end
        end
    endtask

    task automatic test_toggle_run();
        drive(1'b1, 1'b0, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 3;
            if (out1 !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL run_table[%0d] got=%b want=%b", i, out1, (i % 2 == 0));
            end
            if (out1 !== e1) begin
                bad++;
                $display("FAIL run_model1[%0d] got=%b want=%b", i, out1, e1);
            end
            if (out0 !== e0) begin
                bad++;
                $display("FAIL run_model0[%0d] got=%b want=%b", i, out0, e0);
            end
        end
    endtask

    task automatic test_matching_hold();
        logic xs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic ys [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ex [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b0, 1'b0, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 6; i++) begin
            drive(xs[i], ys[i], 1'b0);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 3;
            if (out1 !== ex[i]) begin
                bad++;
                $display("FAIL hold_table[%0d] got=%b want=%b", i, out1, ex[i]);
            end
            if (out1 !== e1) begin
                bad++;
                $display("FAIL hold_model1[%0d] got=%b want=%b", i, out1, e1);
            end
            if (out0 !== e0) begin
                bad++;
                $display("FAIL hold_model0[%0d] got=%b want=%b", i, out0, e0);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic xs [3] = '{1'b1, 1'b0, 1'b0};
        logic ys [3] = '{1'b0, 1'b1, 1'b1};
        logic rs [3] = '{1'b0, 1'b1, 1'b0};
        logic ex [3] = '{1'b1, 1'b0, 1'b1};
        drive(1'b0, 1'b0, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], ys[i], rs[i]);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 3;
            if (out1 !== ex[i]) begin
                bad++;
                $display("FAIL mid_table[%0d] got=%b want=%b", i, out1, ex[i]);
            end
            if (out1 !== e1) begin
                bad++;
                $display("FAIL mid_model1[%0d] got=%b want=%b", i, out1, e1);
            end
            if (out0 !== e0) begin
                bad++;
                $display("FAIL mid_model0[%0d] got=%b want=%b", i, out0, e0);
            end
        end
    endtask

    task automatic test_init_zero();
        logic xs [2] = '{1'b0, 1'b1};
        logic ys [2] = '{1'b1, 1'b0};
        logic ex [2] = '{1'b0, 1'b1};
        drive(1'b1, 1'b1, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(xs[i], ys[i], 1'b0);
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 2;
            if (out0 !== ex[i]) begin
                bad++;
                $display("FAIL init0_table[%0d] got=%b want=%b", i, out0, ex[i]);
            end
            if (out1 !== e1) begin
                bad++;
                $display("FAIL init0_model1[%0d] got=%b want=%b", i, out1, e1);
            end
        end
    endtask

    task automatic test_random(input bit correlated);
        int ones1;
        int ones0;
        int both;
        int mm;
        int want1;
        int want0;
        int unsigned ua;
        int unsigned ub;
        logic xi;
        logic yi;
        ones1 = 0;
        ones0 = 0;
        both  = 0;
        mm    = 0;
        drive(1'b0, 1'b0, 1'b1);
        void'(q1.pop_front());
        void'(q0.pop_front());
        for (int i = 0; i < 1024; i++) begin
            ua = $urandom_range(0, 99);
            ub = correlated ? ua : $urandom_range(0, 99);
            xi = (ua < 75);
            yi = (ub < 25);
            if (xi && yi) both++;
            if (xi != yi) mm++;
            drive(xi, yi, 1'b0);
            if (out1 === 1'b1) ones1++;
            if (out0 === 1'b1) ones0++;
            e1 = q1.pop_front();
            e0 = q0.pop_front();
            total += 2;
            if (out1 !== e1) begin
                bad++;
                $display("FAIL rand%0d_out1[%0d] got=%b want=%b", correlated, i, out1, e1);
            end
            if (out0 !== e0) begin
                bad++;
                $display("FAIL rand%0d_out0[%0d] got=%b want=%b", correlated, i, out0, e0);
            end
        end
        want1 = both + (mm + 1) / 2;
        want0 = both + mm / 2;
        total += 2;
        if (ones1 < want1 - 1 || ones1 > want1 + 1) begin
            bad++;
            $display("FAIL rand%0d_count1 got=%0d want=%0d+/-1", correlated, ones1, want1);
        end
        if (ones0 < want0 - 1 || ones0 > want0 + 1) begin
            bad++;
            $display("FAIL rand%0d_count0 got=%0d want=%0d+/-1", correlated, ones0, want0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        x     = 1'b0;
        y     = 1'b0;
        p1    = 1'b1;
        p0    = 1'b0;
        test_reset();
        test_basic_sequence();
        test_toggle_run();
        test_matching_hold();
        test_midstream_reset();
        test_init_zero();
        test_random(1'b1);
        test_random(1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
